// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: sequencer state encoding, default PC step and the IF/ID bubble.
// Pure declarations. There is no latency or backpressure.
package fetch_pkg;
    typedef enum logic [1:0] {
        RUN           = 2'd0,
        WAIT_IMEM     = 2'd1,
        REDIRECT_PEND = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES_DEF = 4;

    // addi x0,x0,0 -- the bubble IF/ID loads on flush
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/sat_counter.sv
// Saturating event counter that counts up on inc and holds at all-ones.
// Count is visible one cycle after inc. There is no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: picks the next PC and drives the PC and IF/ID hold/flush controls.
// Controls are combinational from state and inputs. mem_stall freezes everything and imem_ready gates PC advance.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      pc_cur,
    output logic [ADDR_W-1:0]      pc_in,
    output logic                   pc_freeze,
    output logic                   imem_req,
    input  logic                   imem_ready,
    input  logic                   hazard,
    input  logic                   mem_stall,
    input  logic                   branch_taken,
    input  logic [ADDR_W-1:0]      branch_target,
    output logic                   if_id_freeze,
    output logic                   if_id_flush,
    output logic                   redirect_pend,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pend_target, pend_target_nxt;
    logic [ADDR_W-1:0] pc_seq;

    assign pc_seq        = pc_cur + ADDR_W'(INSTR_BYTES);
    assign redirect_pend = (state == REDIRECT_PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pend_target <= '0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pend_target_nxt = pend_target;
        pc_in           = pc_seq;
        pc_freeze       = 1'b0;
        imem_req        = 1'b1;
        if_id_freeze    = 1'b0;
        if_id_flush     = 1'b0;

        if (mem_stall) begin
            // EX is frozen too and will re-present any branch, so drop it here
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            imem_req     = 1'b0;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            if (imem_ready) begin
                pc_in     = branch_target;
                state_nxt = RUN;
            end else begin
                pc_freeze       = 1'b1;
                pend_target_nxt = branch_target;
                state_nxt       = REDIRECT_PEND;
            end
        end else if (hazard) begin
            pc_freeze = 1'b1;
            // while a redirect is pending IF/ID holds wrong-path work, so flush beats freeze
            if (state == REDIRECT_PEND)
                if_id_flush  = 1'b1;
            else
                if_id_freeze = 1'b1;
        end else if (!imem_ready) begin
            pc_freeze   = 1'b1;
            if_id_flush = 1'b1;
            if (state != REDIRECT_PEND)
                state_nxt = WAIT_IMEM;
        end else begin
            if (state == REDIRECT_PEND) begin
                pc_in       = pend_target;
                if_id_flush = 1'b1;
            end
            state_nxt = RUN;
        end
    end

    sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_freeze),
        .count (stall_cycles)
    );
endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_reg;
    logic        imem_ready = 1'b1, hazard = 1'b0, mem_stall = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_target = '0;

    logic [31:0] pc_in, pc_in2;
    logic        pc_freeze, imem_req, if_id_freeze, if_id_flush, redirect_pend;
    logic        pc_freeze2, imem_req2, if_id_freeze2, if_id_flush2, redirect_pend2;
    logic [15:0] stall_cycles;
    logic [1:0]  stall_cycles2;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    // PC register the sequencer steers
    always @(posedge clk or posedge rst) begin
        if (rst)             pc_reg <= '0;
        else if (!pc_freeze) pc_reg <= pc_in;
    end

    fetch_sequencer #(.ADDR_W(32), .INSTR_BYTES(4), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_reg), .pc_in(pc_in), .pc_freeze(pc_freeze),
        .imem_req(imem_req), .imem_ready(imem_ready), .hazard(hazard), .mem_stall(mem_stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .if_id_freeze(if_id_freeze),
        .if_id_flush(if_id_flush), .redirect_pend(redirect_pend), .stall_cycles(stall_cycles)
    );

    // narrow-counter copy to exercise saturation
    fetch_sequencer #(.ADDR_W(32), .INSTR_BYTES(4), .STALL_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .pc_cur(pc_reg), .pc_in(pc_in2), .pc_freeze(pc_freeze2),
        .imem_req(imem_req2), .imem_ready(imem_ready), .hazard(hazard), .mem_stall(mem_stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .if_id_freeze(if_id_freeze2),
        .if_id_flush(if_id_flush2), .redirect_pend(redirect_pend2), .stall_cycles(stall_cycles2)
    );

    typedef struct packed {
        logic [31:0] pc_in;
        logic        frz, req, ifz, ifl, rp;
        logic [15:0] stall;
        logic [31:0] pc_in2;
        logic        frz2, req2, ifz2, ifl2, rp2;
        logic [1:0]  stall2;
    } obs_t;

    typedef struct packed {
        logic        ms, bt, hz, rdy;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic        e_frz, e_req, e_ifz, e_ifl, e_rp;
    } stim_t;

    obs_t sb[$];

    function automatic stim_t mk(input int ms, input int bt, input int hz, input int rdy,
                                 input logic [31:0] tgt, input logic [31:0] e_pc,
                                 input int frz, input int req, input int ifz, input int ifl,
                                 input int rp);
        stim_t s;
        s.ms = 1'(ms); s.bt = 1'(bt); s.hz = 1'(hz); s.rdy = 1'(rdy);
        s.tgt = tgt; s.e_pc = e_pc;
        s.e_frz = 1'(frz); s.e_req = 1'(req); s.e_ifz = 1'(ifz); s.e_ifl = 1'(ifl); s.e_rp = 1'(rp);
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pc_in = pc_in; o.frz = pc_freeze; o.req = imem_req; o.ifz = if_id_freeze;
        o.ifl = if_id_flush; o.rp = redirect_pend; o.stall = stall_cycles;
        o.pc_in2 = pc_in2; o.frz2 = pc_freeze2; o.req2 = imem_req2; o.ifz2 = if_id_freeze2;
        o.ifl2 = if_id_flush2; o.rp2 = redirect_pend2; o.stall2 = stall_cycles2;
        return o;
    endfunction

    // drive one cycle of stimulus and queue what both instances must show for it
    task automatic apply(input stim_t s);
        obs_t e;
        mem_stall = s.ms; branch_taken = s.bt; hazard = s.hz; imem_ready = s.rdy;
        branch_target = s.tgt;
        e.pc_in = s.e_pc; e.frz = s.e_frz; e.req = s.e_req; e.ifz = s.e_ifz; e.ifl = s.e_ifl;
        e.rp = s.e_rp; e.stall = 16'(exp_stall);
        e.pc_in2 = s.e_pc; e.frz2 = s.e_frz; e.req2 = s.e_req; e.ifz2 = s.e_ifz; e.ifl2 = s.e_ifl;
        e.rp2 = s.e_rp; e.stall2 = (exp_stall > 3) ? 2'd3 : 2'(exp_stall);
        sb.push_back(e);
        if (s.e_frz) exp_stall = exp_stall + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_stall = 0; branch_taken = 0; hazard = 0; imem_ready = 1; branch_target = '0;
        exp_stall = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t act, exp;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (stall_cycles !== 16'd0 || redirect_pend !== 1'b0 || stall_cycles2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: stall=%0d rp=%b stall2=%0d, want 0 0 0",
                     stall_cycles, redirect_pend, stall_cycles2);
        end
        do_reset();
        s.push_back(mk(0,0,0,1, 32'h0, 32'h4, 0,1,0,0,0));
        foreach (s[i]) begin
            apply(s[i]); #1;
            act = sample(); exp = sb.pop_front(); n_checks++;
            if (act !== exp) begin
                n_fail++; $display("FAIL reset_first[%0d]: got %h want %h", i, act, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_straight_and_hazard();
        stim_t s[$];
        obs_t act, exp;
        s.push_back(mk(0,0,0,1, 32'h0, 32'h8,  0,1,0,0,0));   // pc 4
        s.push_back(mk(0,0,0,1, 32'h0, 32'hC,  0,1,0,0,0));   // pc 8
        s.push_back(mk(0,0,0,1, 32'h0, 32'h10, 0,1,0,0,0));   // pc C
        foreach (s[i]) begin
            apply(s[i]); #1;
            act = sample(); exp = sb.pop_front(); n_checks++;
            if (act !== exp) begin
                n_fail++; $display("FAIL straight[%0d]: got %h want %h", i, act, exp);
            end
            @(negedge clk);
        end
        do_reset();
        s.delete();
        s.push_back(mk(0,0,0,1, 32'h0, 32'h4,  0,1,0,0,0));   // pc 0
        s.push_back(mk(0,0,0,1, 32'h0, 32'h8,  0,1,0,0,0));   // pc 4
        s.push_back(mk(0,0,1,1, 32'h0, 32'hC,  1,1,1,0,0));   // hazard at pc 8
        s.push_back(mk(0,0,1,1, 32'h0, 32'hC,  1,1,1,0,0));
        s.push_back(mk(0,0,0,1, 32'h0, 32'hC,  0,1,0,0,0));   // stall count now 2
        foreach (s[i]) begin
            apply(s[i]); #1;
            act = sample(); exp = sb.pop_front(); n_checks++;
            if (act !== exp) begin
                n_fail++; $display("FAIL hazard[%0d]: got %h want %h", i, act, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_and_redirect();
        stim_t s[$];
        obs_t act, exp;
        s.push_back(mk(0,1,0,1, 32'h100, 32'h100, 0,1,0,1,0)); // pc C, immediate redirect
        s.push_back(mk(0,0,0,1, 32'h0,   32'h104, 0,1,0,0,0));
        s.push_back(mk(0,1,0,0, 32'h200, 32'h108, 1,1,0,1,0)); // pc 104, imem busy
        s.push_back(mk(0,0,0,0, 32'h0,   32'h108, 1,1,0,1,1));
        s.push_back(mk(0,0,0,0, 32'h0,   32'h108, 1,1,0,1,1));
        s.push_back(mk(0,0,0,1, 32'h0,   32'h200, 0,1,0,1,1));
        s.push_back(mk(0,0,0,1, 32'h0,   32'h204, 0,1,0,0,0)); // pc 200
        s.push_back(mk(0,1,0,0, 32'h250, 32'h208, 1,1,0,1,0)); // pc 204
        s.push_back(mk(0,1,0,0, 32'h300, 32'h208, 1,1,0,1,1)); // younger target
        s.push_back(mk(0,0,1,0, 32'h0,   32'h208, 1,1,0,1,1)); // hazard while pending: flush wins
        s.push_back(mk(0,0,0,1, 32'h0,   32'h300, 0,1,0,1,1));
        s.push_back(mk(0,0,0,0, 32'h0,   32'h304, 1,1,0,1,0)); // pc 300, plain wait
        s.push_back(mk(0,0,0,1, 32'h0,   32'h304, 0,1,0,0,0));
        foreach (s[i]) begin
            apply(s[i]); #1;
            act = sample(); exp = sb.pop_front(); n_checks++;
            if (act !== exp) begin
                n_fail++; $display("FAIL redirect[%0d]: got %h want %h", i, act, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_stall();
        stim_t s[$];
        obs_t act, exp;
        s.push_back(mk(1,1,0,1, 32'h400, 32'h308, 1,0,1,0,0)); // pc 304, branch ignored
        s.push_back(mk(1,1,0,1, 32'h400, 32'h308, 1,0,1,0,0));
        s.push_back(mk(1,0,1,0, 32'h0,   32'h308, 1,0,1,0,0));
        s.push_back(mk(0,1,0,1, 32'h400, 32'h400, 0,1,0,1,0)); // re-presented
        s.push_back(mk(0,1,0,0, 32'h500, 32'h404, 1,1,0,1,0)); // pc 400
        s.push_back(mk(1,0,0,0, 32'h0,   32'h404, 1,0,1,0,1)); // stall while pending: freeze wins
        s.push_back(mk(0,0,0,1, 32'h0,   32'h500, 0,1,0,1,1));
        s.push_back(mk(0,1,1,1, 32'h600, 32'h600, 0,1,0,1,0)); // pc 500, branch beats hazard
        s.push_back(mk(0,1,0,0, 32'h700, 32'h604, 1,1,0,1,0)); // pc 600, go pending
        foreach (s[i]) begin
            apply(s[i]); #1;
            act = sample(); exp = sb.pop_front(); n_checks++;
            if (act !== exp) begin
                n_fail++; $display("FAIL mem_stall[%0d]: got %h want %h", i, act, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[$];
        obs_t act, exp;
        do_reset();
        s.push_back(mk(0,0,0,1, 32'h0, 32'h4, 0,1,0,0,0));     // pending target 0x700 discarded
        s.push_back(mk(0,0,0,1, 32'h0, 32'h8, 0,1,0,0,0));
        foreach (s[i]) begin
            apply(s[i]); #1;
            act = sample(); exp = sb.pop_front(); n_checks++;
            if (act !== exp) begin
                n_fail++; $display("FAIL reset_mid[%0d]: got %h want %h", i, act, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_straight_and_hazard();
        test_branch_and_redirect();
        test_mem_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
